// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default width for the bit-serial adder.
package serial_add_pkg;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;
   localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder, the shared datapath cell of the serial adder.
module full_adder (
   input  logic a_in,
   input  logic b_in,
   input  logic c_in,
   output logic sum,
   output logic carry
);
   assign sum   = a_in ^ b_in ^ c_in;
   assign carry = (a_in & b_in) | (c_in & (a_in ^ b_in));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, one bit pair per cycle through a single full_adder.
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
   logic             carry_q;
   logic             fa_sum, fa_carry;

   full_adder u_fa (
      .a_in (a_sh[0]),
      .b_in (b_sh[0]),
      .c_in (carry_q),
      .sum  (fa_sum),
      .carry(fa_carry)
   );

   // Handshake flags decode straight from the state register; no input-to-output path.
   assign in_ready  = state_q == S_IDLE;
   assign out_valid = state_q == S_DONE;
   assign busy      = state_q != S_IDLE;
   assign sum       = sum_sh;
   assign carry_out = carry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               a_sh    <= a_in;
               b_sh    <= b_in;
               carry_q <= c_in;
               cnt_q   <= '0;
               state_q <= S_ADD;
            end
            S_ADD: begin
               sum_sh  <= {fa_sum, sum_sh[WIDTH-1:1]};
               carry_q <= fa_carry;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               // Counter parks on the last index instead of wrapping.
               cnt_q   <= (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
               state_q <= (cnt_q == LAST) ? S_DONE : S_ADD;
            end
            S_DONE: if (out_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed + random scoreboard bench for the 8-bit serial adder.
module tb_serial_adder_ctrl;
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, c_in = 1'b0;
   logic [7:0] a_in = '0, b_in = '0;
   logic       in_ready, out_valid, carry_out, busy;
   logic [7:0] sum;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_in     (a_in),
      .b_in     (b_in),
      .c_in     (c_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .carry_out(carry_out),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [8:0] exp_q[$];
   int checks = 0, errors = 0;
   int acc_cyc = 0, prev_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic hold, input logic b2b);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("in_ready_idle", 32'(in_ready), 1);
      a_in = a;
      b_in = b;
      c_in = c;
      in_valid = 1'b1;
      tick();
      acc_cyc = cyc;
      in_valid = hold;
      a_in = ~a;
      b_in = ~b;
      c_in = ~c;
      chk("busy_add", 32'(busy), 1);
      if (b2b) chk("issue_period", 32'(acc_cyc - prev_acc), 10);
      prev_acc = acc_cyc;
      exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
   endtask

   task automatic collect(input int bp);
      int n = 0;
      logic [8:0] e;
      logic [7:0] s0;
      out_ready = (bp == 0);
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("latency", 32'(cyc - acc_cyc), 8);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'(exp_q.size()), 1);
         e = '0;
      end else e = exp_q.pop_front();
      chk("sum", 32'(sum), 32'(e[7:0]));
      chk("carry_out", 32'(carry_out), 32'(e[8]));
      s0 = sum;
      for (int i = 0; i < bp; i++) begin
         tick();
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_sum_stable", 32'(sum), 32'(s0));
         chk("bp_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("in_ready_after_hs", 32'(in_ready), 1);
      chk("out_valid_after_hs", 32'(out_valid), 0);
   endtask

   initial begin
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sum", 32'(sum), 0);
      chk("rst_carry_out", 32'(carry_out), 0);
      rst = 1'b0;

      issue(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0); collect(0);
      issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0); collect(0);
      issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0); collect(0);
      issue(8'h00, 8'h00, 1'b0, 1'b0, 1'b0); collect(0);

      issue(8'hC3, 8'h7E, 1'b1, 1'b1, 1'b0); collect(5);

      issue(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(exp_q.pop_back());
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("midrst_no_result", 32'(out_valid), 0);
      end
      issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b0); collect(0);

      issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b0); collect(0);
      issue(8'h80, 8'h80, 1'b1, 1'b0, 1'b1); collect(0);
      issue(8'h7F, 8'h00, 1'b1, 1'b0, 1'b1); collect(0);

      for (int k = 0; k < 1000; k++) begin
         issue(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, k != 0);
         collect(0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
